sram_port_ctrl: RTL and testbench

//  Request/response front-end that sits directly upstream of the single-port SRAM macro (SingleRAM).
//  - Accepts one read or write request at a time on a valid/ready interface.
//  - Generates the RAM's cs/we/oe/addr strobes and owns the shared bidirectional data bus.
//  - Inserts a bus-turnaround cycle between a write and a following read.
//  - Returns read data on a one-cycle response pulse.

---
 rtl/sram_port_ctrl.sv | 131 +++++++++++++
 tb/tb_sram_port_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_ctrl.sv
// rtl/sram_port_ctrl.sv - request/response front-end driving a single-port SRAM macro
// Optional write read-back verify: define RDBACK_CHK_EN.
module sram_port_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  chk_err,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);
    typedef enum logic [1:0] {IDLE, WR, TURN, RD} state_t;

    localparam int            CW      = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [CW-1:0] RD_LAST = CW'(RD_LAT);

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           rd_cnt;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic                    last_wr;
    logic                    rd_last;
`ifdef RDBACK_CHK_EN
    logic                    verify;
`endif

    assign rd_last  = (rd_cnt == RD_LAST);
    assign ram_addr = lat_addr;
    // The bus is only ever driven while writing; the RAM owns it otherwise.
    assign ram_data = (state == WR) ? lat_wdata : {DATA_WIDTH{1'bz}};

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_oe    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    if (req_we)       state_nxt = WR;
                    else if (last_wr) state_nxt = TURN;
                    else              state_nxt = RD;
                end
            end
            WR: begin
                ram_cs = 1'b1;
                ram_we = 1'b1;
`ifdef RDBACK_CHK_EN
                state_nxt = TURN;
`else
                state_nxt = IDLE;
`endif
            end
            TURN: state_nxt = RD;
            RD: begin
                ram_cs = 1'b1;
                ram_oe = 1'b1;
                if (rd_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            last_wr   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= 1'b0;
            if (state == IDLE && req_valid) begin
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (state == WR) last_wr <= 1'b1;
            rd_cnt <= (state == RD && !rd_last) ? rd_cnt + 1'b1 : '0;
            if (state == RD && rd_last) begin
                last_wr <= 1'b0;
`ifdef RDBACK_CHK_EN
                if (!verify) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= ram_data;
                end
`else
                rsp_valid <= 1'b1;
                rsp_rdata <= ram_data;
`endif
            end
        end
    end

`ifdef RDBACK_CHK_EN
    // A verify read is the RD that directly follows a WR/TURN pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            verify  <= 1'b0;
            chk_err <= 1'b0;
        end else begin
            chk_err <= 1'b0;
            if (state == WR) begin
                verify <= 1'b1;
            end else if (state == RD && rd_last && verify) begin
                verify  <= 1'b0;
                chk_err <= (ram_data != lat_wdata);
            end
        end
    end
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb/tb_sram_port_ctrl.sv - self-checking bench for sram_port_ctrl
// Covers RD_LAT=1 (main DUT) and RD_LAT=0 (second DUT); RDBACK_CHK_EN build aware.
`timescale 1ns/1ps
module tb_sram_port_ctrl;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int RD_LAT = 1;
`ifdef RDBACK_CHK_EN
    localparam bit RDBACK = 1'b1;
    localparam int WR_COST = RD_LAT + 4;
    localparam int TURN_AFTER_WR = 0;
`else
    localparam bit RDBACK = 1'b0;
    localparam int WR_COST = 2;
    localparam int TURN_AFTER_WR = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int chk_cnt = 0;

    // main DUT, RD_LAT = 1
    logic          req_valid = 1'b0, req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, rsp_valid, chk_err, ram_cs, ram_we, ram_oe;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;

    sram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .chk_err(chk_err),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_data(ram_data)
    );

    // registered-read SRAM; corrupt forces read data to zero
    logic [DW-1:0] mem1 [16];
    logic [DW-1:0] rq1;
    logic          corrupt = 1'b0;
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem1[ram_addr] <= ram_data;
        if (ram_cs && ram_oe) rq1 <= corrupt ? '0 : mem1[ram_addr];
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? rq1 : 'z;

    // second DUT, RD_LAT = 0, combinational-read SRAM
    logic          r0_valid = 1'b0, r0_we = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r0_ready, r0_rsp_valid, r0_chk, r0_cs, r0_ram_we, r0_oe;
    logic [DW-1:0] r0_rsp_rdata;
    logic [AW-1:0] r0_ram_addr;
    wire  [DW-1:0] r0_ram_data;
    logic [DW-1:0] mem0 [16];

    sram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(r0_valid), .req_ready(r0_ready),
        .req_we(r0_we), .req_addr(r0_addr), .req_wdata(r0_wdata),
        .rsp_valid(r0_rsp_valid), .rsp_rdata(r0_rsp_rdata), .chk_err(r0_chk),
        .ram_cs(r0_cs), .ram_we(r0_ram_we), .ram_oe(r0_oe),
        .ram_addr(r0_ram_addr), .ram_data(r0_ram_data)
    );
    always @(posedge clk) if (r0_cs && r0_ram_we) mem0[r0_ram_addr] <= r0_ram_data;
    assign r0_ram_data = (r0_cs && r0_oe && !r0_ram_we) ? mem0[r0_ram_addr] : 'z;

    // event logs
    int            acc_cyc_q[$];
    logic          acc_we_q[$];
    logic [AW-1:0] acc_addr_q[$];
    logic [DW-1:0] acc_wd_q[$];
    logic          iss_we_q[$];
    logic [AW-1:0] iss_addr_q[$];
    logic [DW-1:0] iss_wd_q[$];
    int            rsp_cyc_q[$];
    logic [DW-1:0] rsp_dat_q[$];
    int            wr_cyc_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_dat_q[$];
    int            turn_cyc_q[$];
    logic [DW-1:0] turn_bus_q[$];
    int            rsp0_cyc_q[$];
    logic [DW-1:0] rsp0_dat_q[$];
    int            acc0_last = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready) begin
                acc_cyc_q.push_back(cyc); acc_we_q.push_back(req_we);
                acc_addr_q.push_back(req_addr); acc_wd_q.push_back(req_wdata);
            end
            if (rsp_valid) begin rsp_cyc_q.push_back(cyc); rsp_dat_q.push_back(rsp_rdata); end
            if (ram_cs && ram_we) begin
                wr_cyc_q.push_back(cyc); wr_addr_q.push_back(ram_addr); wr_dat_q.push_back(ram_data);
            end
            if (!ram_cs && !req_ready) begin turn_cyc_q.push_back(cyc); turn_bus_q.push_back(ram_data); end
            if (chk_err) chk_cnt++;
            if (r0_valid && r0_ready) acc0_last = cyc;
            if (r0_rsp_valid) begin rsp0_cyc_q.push_back(cyc); rsp0_dat_q.push_back(r0_rsp_rdata); end
            if (r0_chk) chk_cnt++;
        end
    end

    // reference model: memory contents plus turnaround rule, evaluated over the accept log
    logic [DW-1:0] ref_mem [16];
    bit            ref_last_wr = 1'b0;
    int            exp_rsp_cyc_q[$];
    logic [DW-1:0] exp_rsp_dat_q[$];
    int            exp_turn_q[$];

    function automatic void model_build();
        exp_rsp_cyc_q.delete(); exp_rsp_dat_q.delete(); exp_turn_q.delete();
        foreach (acc_cyc_q[i]) begin
            if (acc_we_q[i]) begin
                ref_mem[acc_addr_q[i]] = acc_wd_q[i];
                if (RDBACK) begin
                    exp_turn_q.push_back(acc_cyc_q[i] + 2);
                    ref_last_wr = 1'b0;
                end else begin
                    ref_last_wr = 1'b1;
                end
            end else begin
                int t;
                t = ref_last_wr ? 1 : 0;
                if (ref_last_wr) exp_turn_q.push_back(acc_cyc_q[i] + 1);
                exp_rsp_cyc_q.push_back(acc_cyc_q[i] + RD_LAT + 2 + t);
                exp_rsp_dat_q.push_back(ref_mem[acc_addr_q[i]]);
                ref_last_wr = 1'b0;
            end
        end
    endfunction

    task automatic clear_logs();
        acc_cyc_q.delete(); acc_we_q.delete(); acc_addr_q.delete(); acc_wd_q.delete();
        iss_we_q.delete(); iss_addr_q.delete(); iss_wd_q.delete();
        rsp_cyc_q.delete(); rsp_dat_q.delete(); wr_cyc_q.delete(); wr_addr_q.delete();
        wr_dat_q.delete(); turn_cyc_q.delete(); turn_bus_q.delete();
        rsp0_cyc_q.delete(); rsp0_dat_q.delete();
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit hold);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        iss_we_q.push_back(we); iss_addr_q.push_back(a); iss_wd_q.push_back(d);
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = req_ready;
            @(posedge clk); #1;
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL send_timeout: addr %0h not accepted in 50 cycles", a); end
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic send0(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        ok = 1'b0;
        r0_valid = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = r0_ready;
            @(posedge clk); #1;
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL send0_timeout: addr %0h not accepted", a); end
        r0_valid = 1'b0;
    endtask

    task automatic test_reset();
        int c0;
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        n_tests++; if (ram_cs !== 1'b0)    begin n_fail++; $display("FAIL rst_ram_cs: got %b want 0", ram_cs); end
        n_tests++; if (ram_we !== 1'b0)    begin n_fail++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
        n_tests++; if (ram_oe !== 1'b0)    begin n_fail++; $display("FAIL rst_ram_oe: got %b want 0", ram_oe); end
        n_tests++; if (ram_addr !== '0)    begin n_fail++; $display("FAIL rst_ram_addr: got %0h want 0", ram_addr); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_tests++; if (rsp_rdata !== '0)   begin n_fail++; $display("FAIL rst_rsp_rdata: got %0h want 0", rsp_rdata); end
        n_tests++; if (chk_err !== 1'b0)   begin n_fail++; $display("FAIL rst_chk_err: got %b want 0", chk_err); end
        rst = 1'b0;
        drain(1);
        c0 = chk_cnt;
        send(1'b0, 4'd6, '0, 1'b0);
        n_tests++; if (ram_oe !== 1'b1) begin n_fail++; $display("FAIL rst_rd_entered: ram_oe got %b want 1", ram_oe); end
        #2 rst = 1'b1;
        clear_logs();
        #1;
        n_tests++; if ({ram_cs, ram_we, ram_oe} !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_rd_strobes: got %b want 000", {ram_cs, ram_we, ram_oe});
        end
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rd_ready: got %b want 0", req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        ref_last_wr = 1'b0;
        drain(RD_LAT + 5);
        n_tests++; if (rsp_cyc_q.size() != 0) begin
            n_fail++; $display("FAIL rst_no_rsp: got %0d responses want 0", rsp_cyc_q.size());
        end
        n_tests++; if (chk_cnt != c0) begin n_fail++; $display("FAIL rst_no_chk: got %0d pulses want 0", chk_cnt - c0); end
    endtask

    task automatic test_write_read();
        clear_logs();
        send(1'b1, 4'd3, 16'hA5A5, 1'b0);
        send(1'b0, 4'd3, '0, 1'b0);
        drain(RD_LAT + 6);
        model_build();
        n_tests++; if (wr_cyc_q.size() != 1) begin
            n_fail++; $display("FAIL wr_cycles: got %0d WR cycles want 1", wr_cyc_q.size());
        end else begin
            n_tests++; if (wr_addr_q[0] !== 4'd3) begin n_fail++; $display("FAIL wr_addr: got %0h want 3", wr_addr_q[0]); end
            n_tests++; if (wr_dat_q[0] !== 16'hA5A5) begin n_fail++; $display("FAIL wr_bus: got %0h want a5a5", wr_dat_q[0]); end
            n_tests++; if (wr_cyc_q[0] != acc_cyc_q[0] + 1) begin
                n_fail++; $display("FAIL wr_timing: got cycle %0d want %0d", wr_cyc_q[0], acc_cyc_q[0] + 1);
            end
        end
        n_tests++; if (turn_cyc_q.size() != exp_turn_q.size()) begin
            n_fail++; $display("FAIL turn_count: got %0d want %0d", turn_cyc_q.size(), exp_turn_q.size());
        end else foreach (exp_turn_q[i]) begin
            n_tests++; if (turn_cyc_q[i] != exp_turn_q[i]) begin
                n_fail++; $display("FAIL turn_cycle: got %0d want %0d", turn_cyc_q[i], exp_turn_q[i]);
            end
            n_tests++; if (turn_bus_q[i] === 16'hA5A5) begin
                n_fail++; $display("FAIL turn_bus_released: got %0h want not a5a5", turn_bus_q[i]);
            end
        end
        n_tests++; if (rsp_cyc_q.size() != 1) begin
            n_fail++; $display("FAIL wr_rd_rsp_count: got %0d want 1", rsp_cyc_q.size());
        end else begin
            n_tests++; if (rsp_dat_q[0] !== 16'hA5A5) begin n_fail++; $display("FAIL wr_rd_data: got %0h want a5a5", rsp_dat_q[0]); end
            n_tests++; if (rsp_cyc_q[0] != exp_rsp_cyc_q[0]) begin
                n_fail++; $display("FAIL wr_rd_latency: got cycle %0d want %0d", rsp_cyc_q[0], exp_rsp_cyc_q[0]);
            end
        end
        n_tests++; if (rsp_rdata !== 16'hA5A5 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rsp_hold: got %0h/%b want a5a5/0", rsp_rdata, rsp_valid);
        end
    endtask

    task automatic test_fill_readback();
        clear_logs();
        for (int i = 0; i < 16; i++) send(1'b1, AW'(i), DW'(i * 16'h1111), 1'b1);
        for (int i = 0; i < 16; i++) send(1'b0, AW'(i), '0, (i != 15));
        drain(RD_LAT + 6);
        model_build();
        n_tests++; if (acc_cyc_q.size() != 32) begin
            n_fail++; $display("FAIL fill_accepts: got %0d want 32", acc_cyc_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_tests++; if (acc_cyc_q[i+1] - acc_cyc_q[i] != WR_COST) begin
                    n_fail++; $display("FAIL fill_wr_spacing: req %0d got %0d want %0d", i, acc_cyc_q[i+1] - acc_cyc_q[i], WR_COST);
                end
            end
            for (int i = 17; i < 31; i++) begin
                n_tests++; if (acc_cyc_q[i+1] - acc_cyc_q[i] != RD_LAT + 2) begin
                    n_fail++; $display("FAIL fill_rd_spacing: req %0d got %0d want %0d", i, acc_cyc_q[i+1] - acc_cyc_q[i], RD_LAT + 2);
                end
            end
        end
        n_tests++; if (turn_cyc_q != exp_turn_q) begin
            n_fail++; $display("FAIL fill_turns: got %0d turn cycles want %0d", turn_cyc_q.size(), exp_turn_q.size());
        end
        n_tests++; if (rsp_dat_q.size() != 16) begin
            n_fail++; $display("FAIL fill_rsp_count: got %0d want 16", rsp_dat_q.size());
        end else foreach (rsp_dat_q[i]) begin
            n_tests++; if (rsp_dat_q[i] !== DW'(i * 16'h1111)) begin
                n_fail++; $display("FAIL fill_data: addr %0d got %0h want %0h", i, rsp_dat_q[i], DW'(i * 16'h1111));
            end
            n_tests++; if (rsp_cyc_q[i] != exp_rsp_cyc_q[i]) begin
                n_fail++; $display("FAIL fill_rsp_cycle: read %0d got %0d want %0d", i, rsp_cyc_q[i], exp_rsp_cyc_q[i]);
            end
        end
    endtask

    task automatic test_mixed_held();
        for (int r = 0; r < 3; r++) begin
            clear_logs();
            for (int i = 0; i < 8; i++)
                send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), (i != 7));
            drain(RD_LAT + 6);
            model_build();
            n_tests++; if (acc_cyc_q.size() != 8) begin
                n_fail++; $display("FAIL mixed_accepts: round %0d got %0d want 8", r, acc_cyc_q.size());
            end else foreach (acc_cyc_q[i]) begin
                n_tests++; if (acc_we_q[i] !== iss_we_q[i] || acc_addr_q[i] !== iss_addr_q[i] ||
                              (iss_we_q[i] && acc_wd_q[i] !== iss_wd_q[i])) begin
                    n_fail++; $display("FAIL mixed_order: req %0d got %b/%0h want %b/%0h", i, acc_we_q[i], acc_addr_q[i], iss_we_q[i], iss_addr_q[i]);
                end
            end
            n_tests++; if (rsp_dat_q.size() != exp_rsp_dat_q.size()) begin
                n_fail++; $display("FAIL mixed_rsp_count: got %0d want %0d", rsp_dat_q.size(), exp_rsp_dat_q.size());
            end else foreach (rsp_dat_q[i]) begin
                n_tests++; if (rsp_dat_q[i] !== exp_rsp_dat_q[i] || rsp_cyc_q[i] != exp_rsp_cyc_q[i]) begin
                    n_fail++; $display("FAIL mixed_rsp: #%0d got %0h@%0d want %0h@%0d", i, rsp_dat_q[i], rsp_cyc_q[i], exp_rsp_dat_q[i], exp_rsp_cyc_q[i]);
                end
            end
        end
    endtask

    task automatic test_rdlat0();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int t1, t2;
        for (int k = 0; k < 4; k++) begin
            clear_logs();
            a = AW'($urandom_range(0, 15));
            d = DW'($urandom);
            send0(1'b1, a, d);
            send0(1'b0, a, '0); t1 = acc0_last;
            send0(1'b0, a, '0); t2 = acc0_last;
            drain(5);
            n_tests++; if (rsp0_dat_q.size() != 2) begin
                n_fail++; $display("FAIL lat0_rsp_count: got %0d want 2", rsp0_dat_q.size());
            end else begin
                n_tests++; if (rsp0_dat_q[0] !== d || rsp0_dat_q[1] !== d) begin
                    n_fail++; $display("FAIL lat0_data: got %0h,%0h want %0h", rsp0_dat_q[0], rsp0_dat_q[1], d);
                end
                n_tests++; if (rsp0_cyc_q[0] != t1 + 2 + TURN_AFTER_WR) begin
                    n_fail++; $display("FAIL lat0_after_wr: got %0d want %0d", rsp0_cyc_q[0], t1 + 2 + TURN_AFTER_WR);
                end
                n_tests++; if (rsp0_cyc_q[1] != t2 + 2) begin
                    n_fail++; $display("FAIL lat0_latency: got %0d want %0d", rsp0_cyc_q[1], t2 + 2);
                end
            end
        end
    endtask

    task automatic test_chk();
`ifdef RDBACK_CHK_EN
        int c0;
        c0 = chk_cnt;
        clear_logs();
        corrupt = 1'b1;
        send(1'b1, 4'd7, 16'h1234, 1'b0);
        drain(RD_LAT + 6);
        corrupt = 1'b0;
        model_build();
        n_tests++; if (chk_cnt - c0 != 1) begin n_fail++; $display("FAIL chk_pulse: got %0d cycles want 1", chk_cnt - c0); end
        n_tests++; if (rsp_cyc_q.size() != 0) begin n_fail++; $display("FAIL chk_no_rsp: got %0d want 0", rsp_cyc_q.size()); end
        c0 = chk_cnt;
        clear_logs();
        send(1'b1, 4'd8, 16'hBEEF, 1'b0);
        drain(RD_LAT + 6);
        model_build();
        n_tests++; if (chk_cnt != c0) begin n_fail++; $display("FAIL chk_clean: got %0d pulses want 0", chk_cnt - c0); end
`else
        n_tests++; if (chk_cnt != 0) begin n_fail++; $display("FAIL chk_tied_low: got %0d pulses want 0", chk_cnt); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_fill_readback();
        test_mixed_held();
        test_rdlat0();
        test_chk();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
